// File: rtl/cdma_ll_fetch.sv
`default_nettype none
// ============================================================================
// Module   : cdma_ll_fetch
// Brief    : Fetches one linked-list descriptor over AXI read, split at 4 KB.
// Revision : 1.0
// ============================================================================
module cdma_ll_fetch #(
    parameter int         LL_WORDS = 6,
    parameter logic [3:0] ARID_VAL = 4'h1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ll_req,
    input  logic [31:0] ll_addr,
    input  logic        cfg_dma_halt,
    output logic        ll_ack,
    output logic        ll_dvld,
    output logic [31:0] ll_rdata,
    output logic [2:0]  ll_dcnt,
    output logic        ll_err,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [3:0]  arid,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
);

    localparam logic [3:0] c_ll_words = 4'(LL_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ACK  = 3'd1,
        S_AR   = 3'd2,
        S_RD   = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_base;
    logic [31:0] r_araddr;
    logic [3:0]  r_wcnt;
    logic [3:0]  r_burst_end;
    logic        r_dvld;
    logic [31:0] r_rdata;
    logic [2:0]  r_dcnt;
    logic        r_err;

    logic [3:0]  w_rem;
    logic [12:0] w_room;
    logic [3:0]  w_beats;
    logic [3:0]  w_wcnt_inc;
    logic        w_rhs;
    logic        w_exp_last;
    logic        w_beat_bad;
    logic        w_start;
    logic        w_unused;

    // Burst length is limited by the remaining words and by the 4 KB page.
    always_comb begin
        w_rem  = c_ll_words - r_wcnt;
        w_room = (13'h1000 - {1'b0, r_araddr[11:0]}) >> 2;
        if ({9'd0, w_rem} < w_room) begin
            w_beats = w_rem;
        end else begin
            w_beats = w_room[3:0];
        end
    end

    assign w_wcnt_inc = r_wcnt + 4'd1;
    assign w_rhs      = rvalid && rready;
    assign w_exp_last = (w_wcnt_inc == r_burst_end);
    assign w_beat_bad = (rresp != 2'b00) || (rlast != w_exp_last);
    assign w_start    = ll_req && !cfg_dma_halt;
    assign w_unused   = ^{rid, ll_addr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_ACK;
            S_ACK:  w_state_nxt = S_AR;
            S_AR:   if (arready) w_state_nxt = S_RD;
            S_RD: begin
                if (w_rhs) begin
                    if (w_beat_bad) begin
                        w_state_nxt = rlast ? S_IDLE : S_ERR;
                    end else if (rlast) begin
                        w_state_nxt = (w_wcnt_inc == c_ll_words) ? S_IDLE : S_AR;
                    end
                end
            end
            S_ERR:  if (w_rhs && rlast) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_base      <= 32'd0;
            r_araddr    <= 32'd0;
            r_wcnt      <= 4'd0;
            r_burst_end <= 4'd0;
            r_dvld      <= 1'b0;
            r_rdata     <= 32'd0;
            r_dcnt      <= 3'd0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dvld  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_base   <= {ll_addr[31:2], 2'b00};
                        r_araddr <= {ll_addr[31:2], 2'b00};
                        r_wcnt   <= 4'd0;
                    end
                end
                S_AR: begin
                    if (arready) r_burst_end <= r_wcnt + w_beats;
                end
                S_RD: begin
                    if (w_rhs) begin
                        if (w_beat_bad) begin
                            r_err <= rlast;
                        end else begin
                            r_dvld   <= 1'b1;
                            r_rdata  <= rdata;
                            r_dcnt   <= r_wcnt[2:0];
                            r_wcnt   <= w_wcnt_inc;
                            // Follow-on burst (if any) resumes right after this word.
                            r_araddr <= r_base + {26'd0, w_wcnt_inc, 2'b00};
                        end
                    end
                end
                S_ERR: begin
                    if (w_rhs && rlast) r_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ll_ack   = (r_state == S_ACK);
    assign ll_dvld  = r_dvld;
    assign ll_rdata = r_rdata;
    assign ll_dcnt  = r_dcnt;
    assign ll_err   = r_err;
    assign arvalid  = (r_state == S_AR);
    assign araddr   = r_araddr;
    assign arlen    = (r_state == S_AR) ? ({4'd0, w_beats} - 8'd1) : 8'd0;
    assign arsize   = 3'b010;
    assign arburst  = 2'b01;
    assign arid     = ARID_VAL;
    assign rready   = (r_state == S_RD) || (r_state == S_ERR);

endmodule
`default_nettype wire
